uart8250_drv: RTL
=================

UART8250_DRV -- requirements
Module: uart8250_drv

Interface
REQ-001 Parameter DIVISOR, default 16'h000C: baud divisor; DLL gets [7:0], DLM gets [15:8].
REQ-002 Parameter FIFO_DEPTH, default 4: byte FIFO entries; power of 2, minimum 2.
REQ-003 clk  input  1  clock; all logic is on the rising edge.
REQ-004 rstn  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  byte offered on in_data.
REQ-006 in_data  input  8  byte to transmit.
REQ-007 in_ready  output  1  FIFO can accept a byte.
REQ-008 init_done  output  1  register init sequence complete.
REQ-009 busy  output  1  FIFO non-empty or FSM outside IDLE.
REQ-010 scr_err  output  1  scratch self-test failed; sticky until reset.
REQ-011 rvalid  output  1  register read strobe to the 8250 port.
REQ-012 raddr  output  3  register read address.
REQ-013 rdata  input  8  read data; valid the cycle after rvalid.
REQ-014 wvalid  output  1  register write strobe.
REQ-015 waddr  output  3  register write address.
REQ-016 wdata  output  8  register write data.

Function
REQ-017 Byte accept: accepted when in_valid && in_ready; in_ready = FIFO not full; first-in first-out order.
REQ-018 A byte pushed into an empty FIFO becomes visible to the FSM on the next cycle.
REQ-019 Bus: at most one of rvalid/wvalid per cycle; each strobe is 1 cycle; no back-to-back strobes.
REQ-020 Addresses: THR/DLL=0, IER/DLM=1, FCR=2, LCR=3, LSR=5, SCR=7.
REQ-021 Init sequence, one write per state, starting the first cycle after reset release:
- LCR=0x80
- DLL=DIVISOR[7:0]
- DLM=DIVISOR[15:8]
- LCR=0x03
- FCR=0x07
- IER=0x00
REQ-022 init_done rises the cycle after the last init state (after the SCR check when enabled); then FSM enters IDLE.
REQ-023 FSM states: INIT_*, [SCR_WR, SCR_RD, SCR_CHK], IDLE, POLL_RD, POLL_WAIT, WR_THR.
REQ-024 IDLE: FIFO non-empty -> POLL_RD; else stay.
REQ-025 POLL_RD: drive rvalid=1, raddr=5; go to POLL_WAIT.
REQ-026 POLL_WAIT: sample rdata; bit5 (THRE)=1 -> WR_THR; else back to POLL_RD (retries unbounded).
REQ-027 WR_THR: drive wvalid=1, waddr=0, wdata=FIFO head; pop FIFO; go to IDLE.
REQ-028 Push and pop in the same cycle: both take effect; count unchanged.
REQ-029 When full, in_ready=0 even during a pop cycle; no combinational ready path.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-031 Bytes are accepted during init; they are transmitted only after init_done.

Reset
REQ-032 rstn=0 values:
- FSM goes to the first init state
- FIFO emptied
- in_ready=0, init_done=0, busy=0, scr_err=0
- rvalid=0, wvalid=0, raddr=0, waddr=0, wdata=0
REQ-033 in_ready goes high the first cycle after rstn=1.
REQ-034 Reset mid-transfer discards FIFO contents and restarts the full init sequence.

Configuration
REQ-035 With UART8250_DRV_SCR_CHECK_EN defined, after IER init:
- SCR_WR writes SCR=0xA5
- SCR_RD reads SCR
- SCR_CHK compares rdata to 0xA5; mismatch sets scr_err=1
- init_done rises in either case
REQ-036 Without UART8250_DRV_SCR_CHECK_EN: SCR states are absent; scr_err is tied 0; init is 6 writes.

Verification
REQ-037 Reset release, macro off -> writes (3,0x80),(0,0x0C),(1,0x00),(3,0x03),(2,0x07),(1,0x00) on cycles 1,3,5,7,9,11; init_done=1 afterwards.
REQ-038 Push 0x41,0x42 with the model returning LSR=0x60 -> LSR read, then THR write 0x41, LSR read, then THR write 0x42; busy falls after the last write.
REQ-039 Model returns LSR=0x00 three times, then 0x60 -> four LSR reads before a single THR write; byte unchanged.
REQ-040 Push 5 bytes back-to-back with FIFO_DEPTH=4 and THRE=0 -> in_ready=0 after the 4th; 5th held; accepted after the first pop.
REQ-041 Macro on, model SCR returns 0x00 -> scr_err=1, init_done=1; with a correct model scr_err stays 0.
REQ-042 rstn pulsed low while 3 bytes are queued -> FIFO empty, no THR write, init sequence restarts from LCR=0x80.

Source files
------------

// File: rtl/uart8250_drv.sv
// Byte-stream driver for an 8250/16550-style UART register port: init sequence, LSR polling, THR writes.
// Optional scratch-register self-test during init: define UART8250_DRV_SCR_CHECK_EN.
module uart8250_drv #(
    parameter logic [15:0] DIVISOR    = 16'h000C,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       init_done,
    output logic       busy,
    output logic       scr_err,
    output logic       rvalid,
    output logic [2:0] raddr,
    input  logic [7:0] rdata,
    output logic       wvalid,
    output logic [2:0] waddr,
    output logic [7:0] wdata
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [2:0] A_THR = 3'd0, A_IER = 3'd1, A_FCR = 3'd2, A_LCR = 3'd3,
                           A_LSR = 3'd5, A_SCR = 3'd7;

    typedef enum logic [3:0] {
        S_INIT_LCR0, S_INIT_DLL, S_INIT_DLM, S_INIT_LCR1, S_INIT_FCR, S_INIT_IER,
`ifdef UART8250_DRV_SCR_CHECK_EN
        S_SCR_WR, S_SCR_RD, S_SCR_CHK,
`endif
        S_IDLE, S_POLL_RD, S_POLL_WAIT, S_WR_THR
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_gap;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_in_ready, r_init_done, r_busy;
    logic          r_rvalid, r_wvalid;
    logic [2:0]    r_raddr, r_waddr;
    logic [7:0]    r_wdata;

    logic          w_push, w_pop, w_wr, w_rd, w_done;
    logic [2:0]    w_addr;
    logic [7:0]    w_data, w_head;
    logic          w_unused;

    assign w_push   = in_valid && r_in_ready;
    assign w_head   = r_mem[r_rd_ptr];
    assign w_unused = ^{rdata[7:6], rdata[4:0]};

    // r_gap stalls the FSM for one cycle after every strobe: it spaces the
    // strobes apart and lets read data arrive before the *_WAIT/CHK state samples it.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        w_addr      = 3'd0;
        w_data      = 8'h00;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        if (!r_gap) begin
            case (r_state)
                S_INIT_LCR0: begin w_wr = 1'b1; w_addr = A_LCR; w_data = 8'h80;          w_state_nxt = S_INIT_DLL;  end
                S_INIT_DLL:  begin w_wr = 1'b1; w_addr = A_THR; w_data = DIVISOR[7:0];   w_state_nxt = S_INIT_DLM;  end
                S_INIT_DLM:  begin w_wr = 1'b1; w_addr = A_IER; w_data = DIVISOR[15:8];  w_state_nxt = S_INIT_LCR1; end
                S_INIT_LCR1: begin w_wr = 1'b1; w_addr = A_LCR; w_data = 8'h03;          w_state_nxt = S_INIT_FCR;  end
                S_INIT_FCR:  begin w_wr = 1'b1; w_addr = A_FCR; w_data = 8'h07;          w_state_nxt = S_INIT_IER;  end
                S_INIT_IER: begin
                    w_wr   = 1'b1;
                    w_addr = A_IER;
                    w_data = 8'h00;
`ifdef UART8250_DRV_SCR_CHECK_EN
                    w_state_nxt = S_SCR_WR;
`else
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
`endif
                end
`ifdef UART8250_DRV_SCR_CHECK_EN
                S_SCR_WR:  begin w_wr = 1'b1; w_addr = A_SCR; w_data = 8'hA5; w_state_nxt = S_SCR_RD;  end
                S_SCR_RD:  begin w_rd = 1'b1; w_addr = A_SCR;                 w_state_nxt = S_SCR_CHK; end
                S_SCR_CHK: begin w_done = 1'b1;                               w_state_nxt = S_IDLE;    end
`endif
                S_IDLE:      if (r_count != '0) w_state_nxt = S_POLL_RD;
                S_POLL_RD:   begin w_rd = 1'b1; w_addr = A_LSR; w_state_nxt = S_POLL_WAIT; end
                S_POLL_WAIT: w_state_nxt = rdata[5] ? S_WR_THR : S_POLL_RD;
                S_WR_THR: begin
                    w_wr        = 1'b1;
                    w_addr      = A_THR;
                    w_data      = w_head;
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_INIT_LCR0;
            endcase
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_INIT_LCR0;
            r_gap       <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_init_done <= 1'b0;
            r_busy      <= 1'b0;
            r_rvalid    <= 1'b0;
            r_wvalid    <= 1'b0;
            r_raddr     <= 3'd0;
            r_waddr     <= 3'd0;
            r_wdata     <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_gap      <= w_wr || w_rd;
            r_rvalid   <= w_rd;
            r_wvalid   <= w_wr;
            if (w_rd) r_raddr <= w_addr;
            if (w_wr) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_count_nxt;
            // Ready is registered from the post-update count, so a full FIFO
            // stays not-ready through its pop cycle.
            r_in_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
            r_busy     <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE) || w_wr || w_rd;
            if (w_done) r_init_done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

`ifdef UART8250_DRV_SCR_CHECK_EN
    logic r_scr_err;
    always_ff @(posedge clk) begin
        if (!rstn)                                         r_scr_err <= 1'b0;
        else if (!r_gap && r_state == S_SCR_CHK && rdata != 8'hA5) r_scr_err <= 1'b1;
    end
    assign scr_err = r_scr_err;
`else
    assign scr_err = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign init_done = r_init_done;
    assign busy      = r_busy;
    assign rvalid    = r_rvalid;
    assign raddr     = r_raddr;
    assign wvalid    = r_wvalid;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
endmodule
